// File: rtl/cart_reload_seq.sv
// -----------------------------------------------------------------------------
// cart_reload_seq
//
// Sequences a cartridge configuration reload for the MSX core. The request is
// debounced first. The core is then held in reset while the new configuration
// is latched. When the new cartridge has SRAM, that SRAM is cleared to 8'hFF
// through the SDRAM arbiter. Finally the core is released.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   reload_req  in   level: current cart config differs from the latched one
//   sram_size   in   [7:0]  new SRAM size in kB (0 = no SRAM); clamped to 32
//   mem_addr    out  [23:0] clear write byte address
//   mem_din     out  [7:0]  clear write data (always 8'hFF)
//   mem_we      out  write request, held until mem_ack
//   mem_ack     in   one-cycle write acknowledge from the SDRAM arbiter
//   core_reset  out  holds the MSX core in reset
//   cfg_latch   out  one-cycle pulse: consumers latch the new cart config
//   busy        out  high whenever the sequencer is not idle
//
// All outputs are registered. Each output is decoded from the next state and
// loaded on the same edge as the state register, so it lines up exactly with
// the state it belongs to.
// -----------------------------------------------------------------------------
module cart_reload_seq #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD    = 16,
    parameter logic [23:0] SRAM_BASE     = 24'h3F8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload_req,
    input  logic [7:0]  sram_size,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        core_reset,
    output logic        cfg_latch,
    output logic        busy
);

    // The debounce and hold phases share one phase counter, sized for the
    // longer of the two.
    localparam int unsigned SC_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned RH_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int unsigned CNT_W = (SC_W > RH_W) ? SC_W : RH_W;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       FILL_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HOLD     = 3'd2,
        ST_LATCH    = 3'd3,
        ST_CLEAR    = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_cnt_nxt;
    logic [15:0]      byte_cnt;
    logic [15:0]      byte_cnt_nxt;
    logic [5:0]       size_kb;
    logic [5:0]       size_kb_nxt;
    logic [23:0]      addr_nxt;

    logic             mem_we_nxt;
    logic             core_reset_nxt;
    logic             cfg_latch_nxt;
    logic             busy_nxt;

    logic [5:0]       clamped_kb;
    logic [15:0]      last_byte;
    logic             ack_take;

    // SRAM larger than 32 kB is clamped to 32 kB. The clamp fits in 6 bits,
    // so size*1024 fits in the 16-bit byte counter.
    assign clamped_kb = (sram_size > 8'd32) ? 6'd32 : sram_size[5:0];

    // Index of the final byte of the clear: size*1024 - 1.
    assign last_byte  = {size_kb, 10'd0} - 16'd1;

    // An acknowledge counts only while a write is actually outstanding.
    assign ack_take   = (state == ST_CLEAR) && mem_we && mem_ack;

    // NOTE: every signal assigned in this always_comb gets a default value
    // first, so that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        byte_cnt_nxt  = byte_cnt;
        size_kb_nxt   = size_kb;
        addr_nxt      = mem_addr;

        case (state)
            ST_IDLE: begin
                if (reload_req) begin
                    state_nxt     = ST_DEBOUNCE;
                    phase_cnt_nxt = '0;
                end
            end

            ST_DEBOUNCE: begin
                if (!reload_req) begin
                    state_nxt     = ST_IDLE;
                    phase_cnt_nxt = '0;
                end else if (phase_cnt == DEB_LAST) begin
                    state_nxt     = ST_HOLD;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_ONE;
                end
            end

            // reload_req is deliberately ignored from here on.
            ST_HOLD: begin
                if (phase_cnt == HOLD_LAST) begin
                    state_nxt     = ST_LATCH;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt + CNT_ONE;
                end
            end

            // The size is captured here, so later changes on sram_size cannot
            // alter the clear length.
            ST_LATCH: begin
                size_kb_nxt  = clamped_kb;
                byte_cnt_nxt = '0;
                addr_nxt     = SRAM_BASE;
                state_nxt    = (clamped_kb == 6'd0) ? ST_RELEASE : ST_CLEAR;
            end

            ST_CLEAR: begin
                if (ack_take) begin
                    // The 24-bit add wraps modulo 2^24 by construction.
                    addr_nxt     = mem_addr + 24'd1;
                    byte_cnt_nxt = byte_cnt + 16'd1;
                    if (byte_cnt == last_byte) begin
                        state_nxt = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Output decode from the next state. core_reset spans HOLD through
        // RELEASE as one contiguous run, so it cannot glitch low in between.
        mem_we_nxt     = (state_nxt == ST_CLEAR);
        core_reset_nxt = (state_nxt inside {ST_HOLD, ST_LATCH, ST_CLEAR, ST_RELEASE});
        cfg_latch_nxt  = (state_nxt == ST_LATCH);
        busy_nxt       = (state_nxt != ST_IDLE);
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset wins over any transition. It also drops mem_we on this
            // same edge, which aborts a clear that is in progress.
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            byte_cnt   <= '0;
            size_kb    <= '0;
            mem_addr   <= SRAM_BASE;
            mem_din    <= FILL_BYTE;
            mem_we     <= 1'b0;
            core_reset <= 1'b0;
            cfg_latch  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            size_kb    <= size_kb_nxt;
            mem_addr   <= addr_nxt;
            mem_din    <= FILL_BYTE;
            mem_we     <= mem_we_nxt;
            core_reset <= core_reset_nxt;
            cfg_latch  <= cfg_latch_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cart_reload_seq.sv
// -----------------------------------------------------------------------------
// tb_cart_reload_seq
//
// Self-checking bench for cart_reload_seq with STABLE_CYCLES=4, RESET_HOLD=3.
// Expected clear writes are pushed to a scoreboard queue when a reload is
// started. Each entry is popped and compared when the arbiter model
// acknowledges the matching write. Inputs change and outputs are sampled
// 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_cart_reload_seq;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned RESET_HOLD    = 3;
    localparam logic [23:0] SRAM_BASE     = 24'h3F8000;

    logic        clk;
    logic        reset;
    logic        reload_req;
    logic [7:0]  sram_size;
    logic [23:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_ack;
    logic        core_reset;
    logic        cfg_latch;
    logic        busy;

    int          tests_run;
    int          tests_failed;
    logic [23:0] exp_q[$];
    int          stab_errs;
    logic [23:0] last_wr_addr;

    cart_reload_seq #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_HOLD    (RESET_HOLD),
        .SRAM_BASE     (SRAM_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reload_req (reload_req),
        .sram_size  (sram_size),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .core_reset (core_reset),
        .cfg_latch  (cfg_latch),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(SRAM_BASE + 24'(i));
        end
    endtask

    // Waits (bounded) for cfg_latch and then drops reload_req.
    task automatic wait_latch(input string name);
        int cyc;
        cyc = 0;
        while (cfg_latch !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        tests_run++;
        if (cfg_latch !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_latch: cfg_latch=%b required 1 within 40 cycles", name, cfg_latch);
        end
        reload_req = 1'b0;
    endtask

    // SDRAM arbiter model: acknowledges each write after 0..max_delay cycles
    // and compares it against the scoreboard. When stop_after is non-zero, the
    // task returns right after raising the stop_after-th acknowledge.
    task automatic serve_writes(input int max_delay, input int stop_after, output int n_done);
        int          ack_wait;
        int          cyc;
        logic [23:0] req_addr;
        logic [23:0] exp_a;
        n_done   = 0;
        ack_wait = -1;
        req_addr = '0;
        cyc      = 0;
        while (mem_we !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        tests_run++;
        if (mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_start: mem_we=%b required 1 within 64 cycles", mem_we);
            return;
        end
        cyc = 0;
        while (mem_we === 1'b1 && cyc < 100000) begin
            if (ack_wait < 0) begin
                req_addr = mem_addr;
                ack_wait = int'($urandom_range(max_delay, 0));
            end else if (mem_addr !== req_addr || mem_din !== 8'hFF) begin
                stab_errs++;
            end
            if (ack_wait == 0) begin
                mem_ack = 1'b1;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL write_extra: got write at %h, required no further writes", mem_addr);
                end else begin
                    exp_a = exp_q.pop_front();
                    if (mem_addr !== exp_a || mem_din !== 8'hFF) begin
                        tests_failed++;
                        $display("FAIL write_data: got %h<=%h required %h<=ff", mem_addr, mem_din, exp_a);
                    end
                end
                last_wr_addr = mem_addr;
                n_done++;
                ack_wait = -1;
                if (stop_after > 0 && n_done == stop_after) return;
            end else begin
                ack_wait--;
            end
            tick();
            mem_ack = 1'b0;
            cyc++;
        end
        tests_run++;
        if (mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_end: mem_we=%b required 0 within cycle budget", mem_we);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        reload_req = 1'b0;
        mem_ack    = 1'b0;
        sram_size  = 8'd0;
        tick();
        tick();
        tests_run += 6;
        if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL rst_core_reset: got %b required 0", core_reset); end
        if (cfg_latch !== 1'b0)  begin tests_failed++; $display("FAIL rst_cfg_latch: got %b required 0", cfg_latch); end
        if (mem_we !== 1'b0)     begin tests_failed++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        if (busy !== 1'b0)       begin tests_failed++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (mem_addr !== SRAM_BASE) begin tests_failed++; $display("FAIL rst_mem_addr: got %h required %h", mem_addr, SRAM_BASE); end
        if (mem_din !== 8'hFF)   begin tests_failed++; $display("FAIL rst_mem_din: got %h required ff", mem_din); end
        reset = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_stays: busy=%b required 0", busy); end
    endtask

    task automatic test_glitch();
        int busy_cyc;
        int bad_cr;
        int bad_latch;
        int bad_we;
        busy_cyc  = 0;
        bad_cr    = 0;
        bad_latch = 0;
        bad_we    = 0;
        reload_req = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 2) reload_req = 1'b0;
            if (busy === 1'b1)       busy_cyc++;
            if (core_reset !== 1'b0) bad_cr++;
            if (cfg_latch !== 1'b0)  bad_latch++;
            if (mem_we !== 1'b0)     bad_we++;
        end
        tests_run += 5;
        if (busy_cyc !== 3)  begin tests_failed++; $display("FAIL glitch_busy: got %0d busy cycles required 3", busy_cyc); end
        if (bad_cr !== 0)    begin tests_failed++; $display("FAIL glitch_core_reset: got %0d high cycles required 0", bad_cr); end
        if (bad_latch !== 0) begin tests_failed++; $display("FAIL glitch_cfg_latch: got %0d pulses required 0", bad_latch); end
        if (bad_we !== 0)    begin tests_failed++; $display("FAIL glitch_mem_we: got %0d high cycles required 0", bad_we); end
        if (busy !== 1'b0)   begin tests_failed++; $display("FAIL glitch_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_no_sram();
        int   cr_cyc;
        int   rises;
        int   latches;
        int   latch_pos;
        int   we_cyc;
        int   deb_cyc;
        logic cr_prev;
        cr_cyc    = 0;
        rises     = 0;
        latches   = 0;
        latch_pos = 0;
        we_cyc    = 0;
        deb_cyc   = 0;
        cr_prev   = 1'b0;
        sram_size  = 8'd0;
        reload_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy === 1'b1 && core_reset === 1'b0 && rises == 0) deb_cyc++;
            if (core_reset === 1'b1) begin
                cr_cyc++;
                if (!cr_prev) rises++;
            end
            if (cfg_latch === 1'b1) begin
                latches++;
                latch_pos  = cr_cyc;
                reload_req = 1'b0;
            end
            if (mem_we !== 1'b0) we_cyc++;
            cr_prev = core_reset;
        end
        tests_run += 7;
        if (deb_cyc !== 4)   begin tests_failed++; $display("FAIL nosram_debounce: got %0d cycles required 4", deb_cyc); end
        if (cr_cyc !== 5)    begin tests_failed++; $display("FAIL nosram_core_reset_len: got %0d required 5", cr_cyc); end
        if (rises !== 1)     begin tests_failed++; $display("FAIL nosram_core_reset_glitch: got %0d rises required 1", rises); end
        if (latches !== 1)   begin tests_failed++; $display("FAIL nosram_latch_count: got %0d required 1", latches); end
        if (latch_pos !== 4) begin tests_failed++; $display("FAIL nosram_latch_pos: got reset cycle %0d required 4", latch_pos); end
        if (we_cyc !== 0)    begin tests_failed++; $display("FAIL nosram_mem_we: got %0d high cycles required 0", we_cyc); end
        if (busy !== 1'b0)   begin tests_failed++; $display("FAIL nosram_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_clear_1k();
        int n;
        exp_q.delete();
        stab_errs  = 0;
        push_clear(1024);
        sram_size  = 8'd1;
        reload_req = 1'b1;
        wait_latch("kb1");
        tick();
        // Change the size after LATCH; the clear length must not follow it.
        sram_size = 8'd5;
        serve_writes(3, 0, n);
        tests_run += 7;
        if (n !== 1024)         begin tests_failed++; $display("FAIL kb1_count: got %0d writes required 1024", n); end
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL kb1_missing: got %0d unwritten required 0", exp_q.size()); end
        if (stab_errs !== 0)    begin tests_failed++; $display("FAIL kb1_stable: got %0d unstable cycles required 0", stab_errs); end
        if (last_wr_addr !== 24'h3F83FF) begin tests_failed++; $display("FAIL kb1_last_addr: got %h required 3f83ff", last_wr_addr); end
        if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL kb1_release_reset: got %b required 1", core_reset); end
        if (busy !== 1'b1)      begin tests_failed++; $display("FAIL kb1_release_busy: got %b required 1", busy); end
        if (cfg_latch !== 1'b0) begin tests_failed++; $display("FAIL kb1_release_latch: got %b required 0", cfg_latch); end
        tick();
        tests_run += 2;
        if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL kb1_idle_reset: got %b required 0", core_reset); end
        if (busy !== 1'b0)      begin tests_failed++; $display("FAIL kb1_idle_busy: got %b required 0", busy); end
        sram_size = 8'd0;
    endtask

    task automatic test_clamp();
        int n;
        exp_q.delete();
        stab_errs  = 0;
        push_clear(32768);
        sram_size  = 8'd200;
        reload_req = 1'b1;
        wait_latch("clamp");
        serve_writes(0, 0, n);
        tests_run += 3;
        if (n !== 32768)        begin tests_failed++; $display("FAIL clamp_count: got %0d writes required 32768", n); end
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL clamp_missing: got %0d unwritten required 0", exp_q.size()); end
        if (last_wr_addr !== 24'h3FFFFF) begin tests_failed++; $display("FAIL clamp_last_addr: got %h required 3fffff", last_wr_addr); end
        tick();
        sram_size = 8'd0;
    endtask

    task automatic test_abort();
        int n;
        int deb_cyc;
        exp_q.delete();
        push_clear(10);
        sram_size  = 8'd2;
        reload_req = 1'b1;
        wait_latch("abort");
        serve_writes(1, 10, n);
        tests_run++;
        if (n !== 10) begin tests_failed++; $display("FAIL abort_acks: got %0d required 10", n); end
        tick();
        // Reset lands together with a further, pending acknowledge.
        reset   = 1'b1;
        mem_ack = 1'b1;
        tick();
        tests_run += 5;
        if (mem_we !== 1'b0)     begin tests_failed++; $display("FAIL abort_mem_we: got %b required 0", mem_we); end
        if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL abort_core_reset: got %b required 0", core_reset); end
        if (busy !== 1'b0)       begin tests_failed++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (cfg_latch !== 1'b0)  begin tests_failed++; $display("FAIL abort_cfg_latch: got %b required 0", cfg_latch); end
        if (mem_addr !== SRAM_BASE) begin tests_failed++; $display("FAIL abort_addr: got %h required %h", mem_addr, SRAM_BASE); end
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        tests_run += 2;
        if (mem_addr !== SRAM_BASE) begin tests_failed++; $display("FAIL abort_stray_ack: addr %h required %h", mem_addr, SRAM_BASE); end
        if (mem_we !== 1'b0)     begin tests_failed++; $display("FAIL abort_stray_we: got %b required 0", mem_we); end

        // A fresh reload must start from DEBOUNCE and clear the full range.
        exp_q.delete();
        stab_errs  = 0;
        push_clear(1024);
        sram_size  = 8'd1;
        reload_req = 1'b1;
        deb_cyc    = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (core_reset === 1'b1) break;
            if (busy === 1'b1) deb_cyc++;
        end
        tests_run++;
        if (deb_cyc !== 4) begin tests_failed++; $display("FAIL restart_debounce: got %0d cycles required 4", deb_cyc); end
        wait_latch("restart");
        serve_writes(0, 0, n);
        tests_run += 3;
        if (n !== 1024)         begin tests_failed++; $display("FAIL restart_count: got %0d writes required 1024", n); end
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL restart_missing: got %0d unwritten required 0", exp_q.size()); end
        if (last_wr_addr !== 24'h3F83FF) begin tests_failed++; $display("FAIL restart_last_addr: got %h required 3f83ff", last_wr_addr); end
        tick();
        sram_size = 8'd0;
    endtask

    task automatic test_back_to_back();
        int   latches;
        int   rises;
        int   gap;
        logic cr_prev;
        logic after_rel;
        logic second;
        latches   = 0;
        rises     = 0;
        gap       = 0;
        cr_prev   = 1'b0;
        after_rel = 1'b0;
        second    = 1'b0;
        sram_size  = 8'd0;
        reload_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (core_reset === 1'b1 && !cr_prev) rises++;
            if (core_reset === 1'b0 && cr_prev && rises == 1) after_rel = 1'b1;
            if (after_rel && !second) begin
                if (busy === 1'b0) gap++;
                else second = 1'b1;
            end
            if (cfg_latch === 1'b1) begin
                latches++;
                if (latches == 2) reload_req = 1'b0;
            end
            cr_prev = core_reset;
        end
        tests_run += 4;
        if (latches !== 2) begin tests_failed++; $display("FAIL b2b_latches: got %0d required 2", latches); end
        if (rises !== 2)   begin tests_failed++; $display("FAIL b2b_resets: got %0d reset runs required 2", rises); end
        if (gap !== 1)     begin tests_failed++; $display("FAIL b2b_idle_gap: got %0d idle cycles required 1", gap); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: busy=%b required 0", busy); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        stab_errs    = 0;
        last_wr_addr = '0;
        reset        = 1'b1;
        reload_req   = 1'b0;
        mem_ack      = 1'b0;
        sram_size    = 8'd0;

        test_reset();
        test_glitch();
        test_no_sram();
        test_clear_1k();
        test_clamp();
        test_abort();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cart_reload_seq.md
CART_RELOAD_SEQ -- requirements
Module: cart_reload_seq

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: cycles reload_req must stay high before a reload starts.
REQ-002 SHALL have parameter RESET_HOLD, default 16: cycles core_reset is held before the config latch.
REQ-003 SHALL have parameter SRAM_BASE, default 24'h3F8000: byte address where the cartridge SRAM clear starts.
REQ-004 SHALL have ports: clk input 1, system clock; reset input 1, synchronous, active-high.
REQ-005 SHALL have reload_req input 1: level; current cart config differs from the latched config.
REQ-006 SHALL have sram_size input 8: new SRAM size in kB (0 = none).
REQ-007 SHALL have mem_addr output 24: clear write address.
REQ-008 SHALL have mem_din output 8: clear write data.
REQ-009 SHALL have mem_we output 1: write request, held until acknowledged.
REQ-010 SHALL have mem_ack input 1: one-cycle write acknowledge from the SDRAM arbiter.
REQ-011 SHALL have core_reset output 1: holds the MSX core in reset.
REQ-012 SHALL have cfg_latch output 1: one-cycle pulse; consumers latch the new cart config.
REQ-013 SHALL have busy output 1: high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, DEBOUNCE, HOLD, LATCH, CLEAR and RELEASE; all outputs SHALL be registered.
REQ-015 IDLE: core_reset=0, mem_we=0; reload_req=1 -> DEBOUNCE, debounce counter cleared to 0.
REQ-016 DEBOUNCE: counter increments each cycle; reload_req=0 -> IDLE with no other output change; counter==STABLE_CYCLES-1 with reload_req=1 -> HOLD.
REQ-017 HOLD: core_reset=1 from the first HOLD cycle; after exactly RESET_HOLD cycles in HOLD -> LATCH; reload_req is ignored.
REQ-018 LATCH: cfg_latch=1 for exactly one cycle; capture size=min(sram_size,32) into an internal register; captured size 0 -> RELEASE, else -> CLEAR with mem_addr=SRAM_BASE and byte counter 0.
REQ-019 CLEAR: mem_we=1, mem_din=8'hFF; mem_addr, mem_din and mem_we SHALL stay stable while mem_ack=0.
REQ-020 CLEAR: on mem_ack=1, mem_addr increments by 1 and the byte counter increments, taking effect next cycle.
REQ-021 CLEAR: the acknowledge of byte number size*1024-1 -> RELEASE; mem_we=0 on the next cycle.
REQ-022 CLEAR: mem_ack while mem_we=0 SHALL be ignored.
REQ-023 CLEAR: the byte counter SHALL be 16 bits wide; mem_addr wraps modulo 2^24 without error.
REQ-024 RELEASE: core_reset stays 1 for this one cycle, then IDLE with core_reset=0.
REQ-025 RELEASE: a reload_req still high in the following IDLE starts a new DEBOUNCE (back-to-back reloads allowed).
REQ-026 core_reset SHALL be continuously 1 from HOLD entry through RELEASE, with no glitch low.
REQ-027 cfg_latch SHALL occur exactly once per completed sequence.
REQ-028 Changes on sram_size after LATCH SHALL NOT affect the clear length.

Reset
REQ-029 reset=1 SHALL force IDLE at the next edge: core_reset=0, cfg_latch=0, mem_we=0, busy=0, mem_addr=SRAM_BASE, mem_din=8'hFF, all counters 0.
REQ-030 reset during CLEAR SHALL abort the clear, dropping mem_we in the same edge; a pending ack after reset SHALL be ignored.
REQ-031 reset SHALL take priority over every state transition.

Verification (bench parameters STABLE_CYCLES=4, RESET_HOLD=3)
REQ-032 Glitch: reload_req high for 3 cycles then low -> core_reset, cfg_latch and mem_we never assert; busy high 3 cycles; back to IDLE.
REQ-033 No SRAM: reload_req held high, sram_size=0 -> core_reset high 5 cycles (3 HOLD + LATCH + RELEASE); cfg_latch pulses on the 4th; mem_we stays 0.
REQ-034 1 kB with random ack: sram_size=1, ack delays 0-3 cycles -> exactly 1024 writes of 8'hFF at 0x3F8000..0x3F83FF; each address written once; addr stable while waiting.
REQ-035 Clamp: sram_size=200 -> exactly 32768 writes, last address 0x3FFFFF.
REQ-036 Abort: reset asserted after 10 acks in CLEAR -> next cycle mem_we=0, core_reset=0, busy=0; a new reload_req restarts cleanly from DEBOUNCE.
REQ-037 Back-to-back: reload_req kept high through RELEASE -> second DEBOUNCE starts the cycle after IDLE; cfg_latch pulses twice in total.
